ilog2_share_ctrl: RTL and testbench
===================================

Name: ilog2_share_ctrl

Overview:
- Shares one pipelined integer-log2 unit between NREQ requesters, for example several chaining lanes that compute gap log terms.
- Arbitrates requests round-robin and issues one 32-bit operand per cycle to the shared unit.
- Tracks every in-flight operation with a tag pipeline matched to the unit's fixed latency.
- Routes each result back to its originating requester and enforces a per-requester outstanding-operation cap.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 5, fixed latency of the shared log2 unit: operand register in cycle c, result valid in cycle c+LAT.
- MAX_OUT, 4, maximum in-flight operations per requester (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_value  in  NREQ*32  per-requester operand; slice i is [32*i+31:32*i].
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- log_v  out  32  registered operand to the shared log2 unit.
- log_log2  in  5  result from the shared unit, aligned LAT cycles after log_v.
- resp_valid  out  NREQ  one-hot, single-cycle result strobe.
- resp_log2  out  5  result value; meaningful only while any resp_valid bit is set.
- resp_zero  out  1  operand was 0; resp_log2 forced to 0.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (async): all outputs are 0; rr pointer = NREQ-1; all outstanding counters = 0; tag pipeline cleared. A reset mid-operation silently drops all in-flight operations and produces no responses.
- Eligibility: requester i is eligible when req_valid[i] && cnt[i] < MAX_OUT.
- Grant:
  - Combinational; at most one bit of req_ready is set.
  - The grant goes to the first eligible index searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - On a transfer, ptr <= granted index. With no transfer, ptr holds.
- Handshake rules: req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready, and must hold req_value stable while valid and not accepted.
- Issue:
  - On a transfer in cycle t: log_v <= operand in t+1.
  - Tag stage 0 <= {valid=1, id=i, zero=(operand==0)}.
  - With no transfer: log_v <= 0 and tag valid <= 0.
- Tag pipeline:
  - LAT-deep shift register of {valid, id[$clog2(NREQ)-1:0], zero}, advancing every cycle with no stall.
  - The head aligns with log_log2.
- Response:
  - Registered.
  - resp_valid[id] <= head.valid.
  - resp_log2 <= head.zero ? 0 : log_log2.
  - resp_zero <= head.valid & head.zero.
  - Total latency is LAT+2 cycles from the transfer edge to the resp_valid cycle.
  - No backpressure: requesters must accept responses.
- Outstanding counters:
  - cnt[i] increments on transfer from i and decrements on resp_valid[i].
  - A simultaneous transfer and response for the same i leaves cnt unchanged.
  - cnt never exceeds MAX_OUT; req_ready[i] is 0 while cnt[i]==MAX_OUT.
- busy = OR of all tag valid bits and the response register valid.
- Ordering: responses to a given requester return in issue order. Throughput is 1 operation/cycle aggregate.
- Boundaries:
  - Operand 0xFFFF_FFFF → the log unit result (31) passes through.
  - Operand 1 → 0 with resp_zero=0.
  - Operand 0 → 0 with resp_zero=1.

Decomposition:
- Shared package ilog2_pkg:
  - LOG_W=5 and VAL_W=32 constants.
  - Tag typedef {valid, id, zero}.
  - NREQ-dependent ID_W function.
- One sub-module, rr_arbiter (NREQ-wide: eligible vector plus pointer in, one-hot grant out), reusable elsewhere. The tag pipeline and counters stay in the top.

Test Plan:
- Single requester: req0 sends 0x0000_0100 at cycle 10 → log_v=0x100 at cycle 11; resp_valid=4'b0001, resp_log2=8, resp_zero=0 at cycle 17 (LAT=5).
- All four requesters valid continuously, ptr starting at 3 → grants 0,1,2,3,0,... one per cycle; responses return in the same order, one per cycle, 7 cycles after each grant.
- Req2 issues 0 → resp_zero=1, resp_log2=0 even though the model's log_log2 drives 5'h1F in that cycle.
- Req1 valid every cycle with log unit latency LAT=5, MAX_OUT=4 → exactly 4 accepts, then req_ready[1]=0 until its first response, then 1 accept per response. cnt[1] never reaches 5.
- Reset asserted while 3 operations are in flight → all outputs 0 immediately, no stale resp_valid after reset release; a new request afterwards returns the correct result at LAT+2.
- Operands 0xFFFF_FFFF, 1, 0x0001_0000 from req3, back-to-back → resp_log2 = 31, 0, 16 in consecutive cycles, all with resp_valid=4'b1000.

Source files
------------

// File: rtl/ilog2_pkg.sv
// Shared constants and tag type for the shared integer-log2 unit and its front end.
package ilog2_pkg;
  localparam int LOG_W    = 5;
  localparam int VAL_W    = 32;
  // Tag id field is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                zero;
  } tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_any_o
);
  always_comb begin
    int j;
    j           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!grant_any_o && eligible_i[j]) begin
        grant_any_o = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ilog2_share_ctrl.sv
// Shares one fixed-latency log2 unit among NREQ requesters: RR issue, tag tracking,
// result routing and a per-requester in-flight cap.
module ilog2_share_ctrl
  import ilog2_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LAT     = 5,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*VAL_W-1:0] req_value,
  output logic [NREQ-1:0]       req_ready,
  output logic [VAL_W-1:0]      log_v,
  input  logic [LOG_W-1:0]      log_log2,
  output logic [NREQ-1:0]       resp_valid,
  output logic [LOG_W-1:0]      resp_log2,
  output logic                  resp_zero,
  output logic                  busy
);
  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0][VAL_W-1:0] val_arr;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q;
  logic [NREQ-1:0]            eligible, gnt, resp_d, resp_valid_q;
  logic [ID_W-1:0]            ptr_q, gnt_idx;
  logic                       xfer;
  logic [VAL_W-1:0]           gnt_val, log_v_q;
  logic [LOG_W-1:0]           resp_log2_q;
  logic                       resp_zero_q;
  // tag_q[0] sits beside log_v; tag_q[LAT] lines up with log_log2.
  tag_t [LAT:0]               tag_q;
  tag_t                       head;

  assign val_arr = req_value;
  assign head    = tag_q[LAT];

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
  end

  rr_arbiter #(.N(NREQ), .IW(ID_W)) u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (gnt),
    .grant_idx_o(gnt_idx),
    .grant_any_o(xfer)
  );

  assign req_ready = reset ? '0 : gnt;
  assign gnt_val   = val_arr[gnt_idx];

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      resp_d[i] = head.valid && (head.id == ID_MAX_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= ID_W'(NREQ - 1);
      log_v_q      <= '0;
      tag_q        <= '0;
      resp_valid_q <= '0;
      resp_log2_q  <= '0;
      resp_zero_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (xfer) ptr_q <= gnt_idx;
      log_v_q        <= xfer ? gnt_val : '0;
      tag_q[0].valid <= xfer;
      tag_q[0].id    <= xfer ? ID_MAX_W'(gnt_idx) : '0;
      tag_q[0].zero  <= xfer && (gnt_val == '0);
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
      resp_valid_q <= resp_d;
      resp_log2_q  <= (head.valid && !head.zero) ? log_log2 : '0;
      resp_zero_q  <= head.valid && head.zero;
      // Simultaneous issue and retire for the same requester nets to zero.
      for (int i = 0; i < NREQ; i++) begin
        case ({gnt[i], resp_valid_q[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    busy = |resp_valid_q;
    for (int k = 0; k <= LAT; k++) busy = busy | tag_q[k].valid;
  end

  assign log_v      = log_v_q;
  assign resp_valid = resp_valid_q;
  assign resp_log2  = resp_log2_q;
  assign resp_zero  = resp_zero_q;
endmodule

// File: tb/tb_ilog2_share_ctrl.sv
// Directed bench for ilog2_share_ctrl with a behavioural fixed-latency log2 unit.
module tb_ilog2_share_ctrl;
  localparam int NREQ = 4, LAT = 5, MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_value;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       log_v;
  logic [4:0]        log_log2;
  logic [NREQ-1:0]   resp_valid;
  logic [4:0]        resp_log2;
  logic              resp_zero;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ilog2_share_ctrl #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .log_v(log_v), .log_log2(log_log2),
    .resp_valid(resp_valid), .resp_log2(resp_log2), .resp_zero(resp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Log unit model: 0 yields 5'h1F, so a zero operand is only correct if the DUT masks it.
  function automatic logic [4:0] flog2(input logic [31:0] v);
    logic [4:0] r;
    r = 5'h1F;
    if (v != 0) begin
      r = 0;
      for (int b = 0; b < 32; b++) if (v[b]) r = 5'(b);
    end
    return r;
  endfunction

  logic [4:0] lpipe [LAT];
  always_ff @(posedge clk) begin
    lpipe[0] <= flog2(log_v);
    for (int k = 1; k < LAT; k++) lpipe[k] <= lpipe[k-1];
  end
  assign log_log2 = lpipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_val(input int r, input logic [31:0] v);
    req_value[32*r +: 32] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " log_v"}, log_v, 0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 0);
    chk({tag, " resp_log2"}, 32'(resp_log2), 0);
    chk({tag, " resp_zero"}, 32'(resp_zero), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // One isolated operation: grant, operand issue, then the response LAT+2 cycles later.
  task automatic run_one(input int r, input logic [31:0] v, input logic [4:0] el, input logic ez);
    req_value = '0;
    set_val(r, v);
    req_valid = NREQ'(1) << r;
    #1;
    chk("vec grant", 32'(req_ready), 32'(NREQ'(1) << r));
    tick();
    req_valid = '0;
    chk("vec log_v", log_v, v);
    chk("vec busy", 32'(busy), 1);
    repeat (LAT) tick();
    chk("vec early resp", 32'(resp_valid), 0);
    tick();
    chk("vec resp_valid", 32'(resp_valid), 32'(NREQ'(1) << r));
    chk("vec resp_log2", 32'(resp_log2), 32'(el));
    chk("vec resp_zero", 32'(resp_zero), 32'(ez));
    tick();
    chk("vec resp clear", 32'(resp_valid), 0);
    chk("vec idle", 32'(busy), 0);
  endtask

  typedef struct {
    int          r;
    logic [31:0] v;
    logic [4:0]  el;
    logic        ez;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int acc8, tbcnt;
    bit iss [64];
    logic [31:0] b2b [3];

    vecs[0] = '{0, 32'h0000_0100,  5'd8, 1'b0};
    vecs[1] = '{2, 32'h0000_0000,  5'd0, 1'b1};
    vecs[2] = '{3, 32'hFFFF_FFFF,  5'd31, 1'b0};
    vecs[3] = '{1, 32'h0000_0001,  5'd0, 1'b0};
    vecs[4] = '{3, 32'h0001_0000,  5'd16, 1'b0};
    vecs[5] = '{0, 32'h8000_0000,  5'd31, 1'b0};
    vecs[6] = '{1, 32'h0000_0003,  5'd1, 1'b0};
    vecs[7] = '{2, 32'h0000_7FFF,  5'd14, 1'b0};

    reset = 1'b1;
    req_valid = '0;
    req_value = '0;
    #1;
    chk_all_zero("reset");
    req_valid = '1;
    #1;
    chk("reset gated ready", 32'(req_ready), 0);
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    foreach (vecs[i]) run_one(vecs[i].r, vecs[i].v, vecs[i].el, vecs[i].ez);

    // Round robin from ptr=3 with all four requesters continuously valid.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < NREQ; i++) set_val(i, 32'h1 << (i + 4));
    for (int n = 0; n <= 12 + LAT + 1; n++) begin
      req_valid = (n < 12) ? '1 : '0;
      #1;
      if (n < 12) chk("rr grant", 32'(req_ready), 32'(NREQ'(1) << (n % 4)));
      if (n >= LAT + 2 && n - LAT - 2 < 12) begin
        chk("rr resp_valid", 32'(resp_valid), 32'(NREQ'(1) << ((n - LAT - 2) % 4)));
        chk("rr resp_log2", 32'(resp_log2), 32'((n - LAT - 2) % 4 + 4));
      end
      tick();
    end
    chk("rr idle", 32'(busy), 0);

    // Outstanding cap on requester 1.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    req_value = '0;
    set_val(1, 32'h0000_0002);
    acc8 = 0; tbcnt = 0;
    foreach (iss[i]) iss[i] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      bit rexp;
      req_valid = 4'b0010;
      #1;
      rexp = (n >= LAT + 2) && iss[n - LAT - 2];
      chk("cap ready", 32'(req_ready), (tbcnt < MAX_OUT) ? 32'h2 : 32'h0);
      chk("cap resp", 32'(resp_valid), rexp ? 32'h2 : 32'h0);
      if (rexp) chk("cap log2", 32'(resp_log2), 1);
      if (n < 8 && req_ready[1]) acc8++;
      iss[n] = (tbcnt < MAX_OUT);
      tbcnt = tbcnt + (iss[n] ? 1 : 0) - (rexp ? 1 : 0);
      tick();
    end
    chk("cap accepts in first 8", 32'(acc8), 4);
    req_valid = '0;
    repeat (LAT + 3) tick();
    chk("cap idle", 32'(busy), 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) set_val(i, 32'h40);
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    repeat (2) tick();
    chk("mid busy", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    chk_all_zero("mid reset");
    repeat (2) tick();
    reset = 1'b0;
    for (int n = 0; n < LAT + 3; n++) begin
      tick();
      chk("stale resp", 32'(resp_valid), 0);
    end
    run_one(2, 32'h0000_0400, 5'd10, 1'b0);

    // Back-to-back boundary operands from requester 3.
    b2b[0] = 32'hFFFF_FFFF; b2b[1] = 32'h0000_0001; b2b[2] = 32'h0001_0000;
    for (int n = 0; n < 3 + LAT + 2; n++) begin
      req_valid = (n < 3) ? 4'b1000 : 4'b0000;
      if (n < 3) set_val(3, b2b[n]);
      #1;
      if (n < 3) chk("b2b grant", 32'(req_ready), 32'h8);
      if (n >= LAT + 2) begin
        chk("b2b resp_valid", 32'(resp_valid), 32'h8);
        chk("b2b resp_log2", 32'(resp_log2), (n == LAT + 2) ? 31 : (n == LAT + 3) ? 0 : 16);
        chk("b2b resp_zero", 32'(resp_zero), 0);
      end
      tick();
    end
    chk("b2b done", 32'(resp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
